// File: rtl/bus_interface_8088.sv
// bus_interface_8088
//   Upstream bus-cycle front end for the 8088 peripheral chain. It latches
//   the multiplexed CPU address on ALE and decodes it against one memory
//   window and one I/O window. It then runs a fixed two-cycle strobe sequence
//   toward the peripherals, followed by EXTRA_WAIT optional wait cycles.
//   Read data is buffered and returned on AD. Write data is buffered and
//   driven on Data.
//
// Ports
//   CLK, RESET       clock, synchronous active-high reset
//   ALE, IOM         CPU address latch enable, I/O (1) / memory (0) select
//   RD_n, WR_n       CPU read/write strobes, active low
//   A_HI             CPU upper address bits
//   AD               CPU multiplexed address/data (bidirectional)
//   READY            CPU ready, low while a decoded transfer is in progress
//   Address          latched address to peripherals
//   MEM_CS, IO_CS    window chip selects, active high, never both high
//   OE, WR           peripheral output/write enables, active low
//   Data             peripheral data bus (bidirectional)
//   dbg_state        current FSM state, for observation only
//
// Handshake: the CPU side has no valid/ready pair. A strobe (RD_n or WR_n
// low) seen in ADDR starts a transfer. READY stays low until the peripheral
// transfer has finished. The CPU then holds its strobe until it has taken
// the data or ended the cycle, and the FSM returns to IDLE when the strobe
// rises.
module bus_interface_8088 #(
    parameter int          ADDR_WIDTH = 20,
    parameter int          DATA_WIDTH = 8,
    parameter int unsigned MEM_BASE   = 0,
    parameter int unsigned MEM_UNITS  = 524288,
    parameter int unsigned IO_BASE    = 16'h0080,
    parameter int unsigned IO_UNITS   = 16,
    parameter int unsigned EXTRA_WAIT = 0
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALE,
    input  logic                  IOM,
    input  logic                  RD_n,
    input  logic                  WR_n,
    input  logic [ADDR_WIDTH-9:0] A_HI,
    inout  wire  [DATA_WIDTH-1:0] AD,
    output logic                  READY,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  MEM_CS,
    output logic                  IO_CS,
    output logic                  OE,
    output logic                  WR,
    inout  wire  [DATA_WIDTH-1:0] Data,
    output logic [3:0]            dbg_state
);

    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] ADDR  = 4'd1;
    localparam logic [3:0] RD1   = 4'd2;
    localparam logic [3:0] RD2   = 4'd3;
    localparam logic [3:0] WT    = 4'd4;
    localparam logic [3:0] RHOLD = 4'd5;
    localparam logic [3:0] WR1   = 4'd6;
    localparam logic [3:0] WR2   = 4'd7;
    localparam logic [3:0] WHOLD = 4'd8;
    localparam logic [3:0] MISS  = 4'd9;

    // Window bounds, one bit wider than the address so the exclusive end
    // cannot wrap.
    localparam logic [ADDR_WIDTH:0] MEM_LO   = (ADDR_WIDTH+1)'(MEM_BASE);
    localparam logic [ADDR_WIDTH:0] MEM_SPAN = (ADDR_WIDTH+1)'(MEM_UNITS);
    localparam logic [16:0]         IO_LO    = 17'(IO_BASE);
    localparam logic [16:0]         IO_SPAN  = 17'(IO_UNITS);

    logic [3:0]            state;
    logic                  mem_hit;
    logic                  io_hit;
    logic                  is_write;
    logic [3:0]            wait_cnt;
    logic [DATA_WIDTH-1:0] rd_latch;
    logic [DATA_WIDTH-1:0] wr_latch;

    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH:0]   mem_off;
    logic [16:0]           io_off;
    logic                  mem_dec;
    logic                  io_dec;

    // Each range check is written as (addr - lo) < span in the widened
    // width. An address below lo wraps to a value at or above 2^ADDR_WIDTH,
    // so it can never pass. This is the same test as lo <= addr < lo + span.
    // IOM is not kept on its own. The two hit flags already carry the cycle
    // type.
    assign next_addr = {A_HI, AD};
    assign mem_off   = {1'b0, next_addr} - MEM_LO;
    assign io_off    = {1'b0, next_addr[15:0]} - IO_LO;
    assign mem_dec   = !IOM && (mem_off < MEM_SPAN);
    assign io_dec    = IOM && (next_addr[ADDR_WIDTH-1:16] == '0) && (io_off < IO_SPAN);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            Address  <= '0;
            mem_hit  <= 1'b0;
            io_hit   <= 1'b0;
            is_write <= 1'b0;
            wait_cnt <= 4'd0;
            rd_latch <= '0;
            wr_latch <= '0;
        end else if (ALE) begin
            // A new address phase takes over from any state, including one
            // in the middle of a transfer.
            state   <= ADDR;
            Address <= next_addr;
            mem_hit <= mem_dec;
            io_hit  <= io_dec;
        end else begin
            case (state)
                ADDR: begin
                    if (!RD_n && WR_n) begin
                        is_write <= 1'b0;
                        state    <= (mem_hit || io_hit) ? RD1 : MISS;
                    end else if (!WR_n && RD_n) begin
                        is_write <= 1'b1;
                        if (mem_hit || io_hit) begin
                            state    <= WR1;
                            wr_latch <= AD;
                        end else begin
                            state <= MISS;
                        end
                    end else if (!RD_n && !WR_n) begin
                        state <= MISS;
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    rd_latch <= Data;
                    if (EXTRA_WAIT > 0) begin
                        state    <= WT;
                        wait_cnt <= 4'(EXTRA_WAIT - 1);
                    end else begin
                        state <= RHOLD;
                    end
                end
                WT: begin
                    if (wait_cnt == 4'd0) state <= is_write ? WHOLD : RHOLD;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RHOLD: if (RD_n) state <= IDLE;
                WR1:   state <= WR2;
                WR2: begin
                    if (EXTRA_WAIT > 0) begin
                        state    <= WT;
                        wait_cnt <= 4'(EXTRA_WAIT - 1);
                    end else begin
                        state <= WHOLD;
                    end
                end
                WHOLD: if (WR_n) state <= IDLE;
                MISS:  if (RD_n && WR_n) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic xfer_rd;
    logic xfer_wr;

    // Outputs depend only on the state, so an abort by ALE or RESET drops
    // every strobe on the same edge that changes the state.
    assign xfer_rd   = (state == RD1) || (state == RD2);
    assign xfer_wr   = (state == WR1) || (state == WR2);
    assign MEM_CS    = (xfer_rd || xfer_wr) && mem_hit;
    assign IO_CS     = (xfer_rd || xfer_wr) && io_hit;
    assign OE        = !xfer_rd;
    assign WR        = !xfer_wr;
    assign READY     = !(xfer_rd || xfer_wr || (state == WT));
    assign dbg_state = state;

    // AD is driven back only while the CPU is reading. Data is driven only
    // in the write strobe states. These two sets of conditions never overlap.
    assign AD   = (state == RHOLD && !RD_n) ? rd_latch :
                  (state == MISS  && !RD_n) ? {DATA_WIDTH{1'b1}} : 'z;
    assign Data = xfer_wr ? wr_latch : 'z;

endmodule

// File: tb/tb_bus_interface_8088.sv
module tb_bus_interface_8088;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_ADDR  = 4'd1;
    localparam logic [3:0] S_RD1   = 4'd2;
    localparam logic [3:0] S_RD2   = 4'd3;
    localparam logic [3:0] S_RHOLD = 4'd5;
    localparam logic [3:0] S_WR1   = 4'd6;
    localparam logic [3:0] S_WR2   = 4'd7;
    localparam logic [3:0] S_WHOLD = 4'd8;
    localparam logic [3:0] S_MISS  = 4'd9;

    // Order of bits in the strobe vector: {MEM_CS, IO_CS, OE, WR, READY}
    localparam logic [4:0] ST_QUIET  = 5'b00111;
    localparam logic [4:0] ST_MEM_RD = 5'b10010;
    localparam logic [4:0] ST_MEM_WR = 5'b10100;
    localparam logic [4:0] ST_IO_WR  = 5'b01100;

    logic        clk;
    logic        reset;
    logic        ale;
    logic        iom;
    logic        rd_n;
    logic        wr_n;
    logic [11:0] a_hi;
    logic        cpu_en;
    logic [7:0]  cpu_ad;
    logic [7:0]  per_rd;

    wire  [7:0]  ad;
    wire  [7:0]  data;
    logic        ready, mem_cs, io_cs, oe, wr;
    logic [19:0] address;
    logic [3:0]  state;

    wire  [7:0]  ad2;
    wire  [7:0]  data2;
    logic        ready2, mem_cs2, io_cs2, oe2, wr2;
    logic [19:0] address2;
    logic [3:0]  state2;

    int tests_run;
    int tests_failed;

    // CPU side drives AD only when it is enabled. Each peripheral model
    // drives its data bus while OE is low.
    assign ad    = cpu_en ? cpu_ad : 8'hzz;
    assign ad2   = cpu_en ? cpu_ad : 8'hzz;
    assign data  = (oe  == 1'b0) ? per_rd : 8'hzz;
    assign data2 = (oe2 == 1'b0) ? per_rd : 8'hzz;

    bus_interface_8088 dut (
        .CLK(clk), .RESET(reset), .ALE(ale), .IOM(iom), .RD_n(rd_n), .WR_n(wr_n),
        .A_HI(a_hi), .AD(ad), .READY(ready), .Address(address), .MEM_CS(mem_cs),
        .IO_CS(io_cs), .OE(oe), .WR(wr), .Data(data), .dbg_state(state)
    );

    bus_interface_8088 #(.EXTRA_WAIT(3)) dut_w3 (
        .CLK(clk), .RESET(reset), .ALE(ale), .IOM(iom), .RD_n(rd_n), .WR_n(wr_n),
        .A_HI(a_hi), .AD(ad2), .READY(ready2), .Address(address2), .MEM_CS(mem_cs2),
        .IO_CS(io_cs2), .OE(oe2), .WR(wr2), .Data(data2), .dbg_state(state2)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: one ALE cycle with the given address. Returns at the next
    // falling edge, with the DUT in ADDR and the CPU no longer driving AD.
    task automatic cpu_latch(input logic io, input logic [19:0] addr);
        ale    = 1'b1;
        iom    = io;
        a_hi   = addr[19:8];
        cpu_ad = addr[7:0];
        cpu_en = 1'b1;
        @(negedge clk);
        ale    = 1'b0;
        cpu_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({mem_cs, io_cs, oe, wr, ready} !== ST_QUIET) begin
            tests_failed++;
            $display("FAIL reset_strobes: got %b expected %b", {mem_cs, io_cs, oe, wr, ready}, ST_QUIET);
        end
        tests_run++;
        if (state !== S_IDLE || address !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_state_addr: got %h/%h expected %h/00000", state, address, S_IDLE);
        end
        reset = 1'b0;
        @(negedge clk);
        // Reset that arrives in the middle of RD1
        cpu_latch(1'b0, 20'h00123);
        rd_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({mem_cs, io_cs, oe, wr, ready} !== ST_MEM_RD) begin
            tests_failed++;
            $display("FAIL reset_pre_rd1: got %b expected %b", {mem_cs, io_cs, oe, wr, ready}, ST_MEM_RD);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({mem_cs, io_cs, oe, wr, ready} !== ST_QUIET || state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL reset_mid_rd1: got %b/%h expected %b/%h", {mem_cs, io_cs, oe, wr, ready}, state, ST_QUIET, S_IDLE);
        end
        tests_run++;
        if (address !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_mid_addr: got %h expected 00000", address);
        end
        reset = 1'b0;
        rd_n  = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mem_read();
        cpu_latch(1'b0, 20'h00123);
        tests_run++;
        if (state !== S_ADDR || address !== 20'h00123) begin
            tests_failed++;
            $display("FAIL mrd_latch: got %h/%h expected %h/00123", state, address, S_ADDR);
        end
        rd_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state !== S_RD1 || {mem_cs, io_cs, oe, wr, ready} !== ST_MEM_RD) begin
            tests_failed++;
            $display("FAIL mrd_rd1: got %h/%b expected %h/%b", state, {mem_cs, io_cs, oe, wr, ready}, S_RD1, ST_MEM_RD);
        end
        @(negedge clk);
        tests_run++;
        if (state !== S_RD2 || {mem_cs, io_cs, oe, wr, ready} !== ST_MEM_RD) begin
            tests_failed++;
            $display("FAIL mrd_rd2: got %h/%b expected %h/%b", state, {mem_cs, io_cs, oe, wr, ready}, S_RD2, ST_MEM_RD);
        end
        @(negedge clk);
        tests_run++;
        if (state !== S_RHOLD || {mem_cs, io_cs, oe, wr, ready} !== ST_QUIET) begin
            tests_failed++;
            $display("FAIL mrd_rhold: got %h/%b expected %h/%b", state, {mem_cs, io_cs, oe, wr, ready}, S_RHOLD, ST_QUIET);
        end
        tests_run++;
        if (ad !== 8'h5A) begin
            tests_failed++;
            $display("FAIL mrd_ad: got %h expected 5a", ad);
        end
        @(negedge clk);
        tests_run++;
        if (ad !== 8'h5A) begin
            tests_failed++;
            $display("FAIL mrd_ad_hold: got %h expected 5a", ad);
        end
        // When RD_n rises, the DUT must release AD so the CPU value shows on it.
        rd_n   = 1'b1;
        cpu_ad = 8'h3C;
        cpu_en = 1'b1;
        #1;
        tests_run++;
        if (ad !== 8'h3C) begin
            tests_failed++;
            $display("FAIL mrd_release: got %h expected 3c", ad);
        end
        @(negedge clk);
        cpu_en = 1'b0;
        tests_run++;
        if (state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL mrd_idle: got %h expected %h", state, S_IDLE);
        end
    endtask

    task automatic test_io_write();
        cpu_latch(1'b1, 20'h00085);
        cpu_ad = 8'hC3;
        cpu_en = 1'b1;
        wr_n   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if ({mem_cs, io_cs, oe, wr, ready} !== ST_IO_WR || data !== 8'hC3) begin
                tests_failed++;
                $display("FAIL iowr_strobe%0d: got %b/%h expected %b/c3", i, {mem_cs, io_cs, oe, wr, ready}, data, ST_IO_WR);
            end
        end
        @(negedge clk);
        tests_run++;
        if (state !== S_WHOLD || {mem_cs, io_cs, oe, wr, ready} !== ST_QUIET) begin
            tests_failed++;
            $display("FAIL iowr_whold: got %h/%b expected %h/%b", state, {mem_cs, io_cs, oe, wr, ready}, S_WHOLD, ST_QUIET);
        end
        wr_n   = 1'b1;
        cpu_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL iowr_idle: got %h expected %h", state, S_IDLE);
        end
    endtask

    task automatic test_miss();
        // The memory window ends at 0x7FFFF, so 0x80000 lies just past it.
        cpu_latch(1'b0, 20'h80000);
        rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (state !== S_MISS || {mem_cs, io_cs, oe, wr, ready} !== ST_QUIET || ad !== 8'hFF) begin
                tests_failed++;
                $display("FAIL miss_mem%0d: got %h/%b/%h expected %h/%b/ff", i, state, {mem_cs, io_cs, oe, wr, ready}, ad, S_MISS, ST_QUIET);
            end
        end
        rd_n = 1'b1;
        @(negedge clk);
        // The I/O window holds ports 0x80..0x8F, so port 0x90 lies just past it.
        cpu_latch(1'b1, 20'h00090);
        cpu_ad = 8'h77;
        cpu_en = 1'b1;
        wr_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (state !== S_MISS || {mem_cs, io_cs, oe, wr, ready} !== ST_QUIET) begin
                tests_failed++;
                $display("FAIL miss_io%0d: got %h/%b expected %h/%b", i, state, {mem_cs, io_cs, oe, wr, ready}, S_MISS, ST_QUIET);
            end
        end
        wr_n   = 1'b1;
        cpu_en = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL miss_idle: got %h expected %h", state, S_IDLE);
        end
    endtask

    task automatic test_extra_wait();
        int low_cycles;
        low_cycles = 0;
        cpu_latch(1'b0, 20'h00123);
        rd_n = 1'b0;
        // The count is bounded. If READY never returns high, the count comes out wrong.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ready2 == 1'b0) low_cycles++;
            else if (low_cycles > 0) break;
        end
        tests_run++;
        if (low_cycles !== 5) begin
            tests_failed++;
            $display("FAIL wait3_ready_low: got %0d cycles expected 5", low_cycles);
        end
        tests_run++;
        if (state2 !== S_RHOLD || ad2 !== 8'h5A) begin
            tests_failed++;
            $display("FAIL wait3_data: got %h/%h expected %h/5a", state2, ad2, S_RHOLD);
        end
        rd_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (state2 !== S_IDLE) begin
            tests_failed++;
            $display("FAIL wait3_idle: got %h expected %h", state2, S_IDLE);
        end
    endtask

    task automatic test_error();
        cpu_latch(1'b0, 20'h00123);
        rd_n = 1'b0;
        wr_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (state !== S_MISS || {mem_cs, io_cs, oe, wr, ready} !== ST_QUIET) begin
                tests_failed++;
                $display("FAIL both_low%0d: got %h/%b expected %h/%b", i, state, {mem_cs, io_cs, oe, wr, ready}, S_MISS, ST_QUIET);
            end
        end
        rd_n = 1'b1;
        wr_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (state !== S_IDLE) begin
            tests_failed++;
            $display("FAIL both_low_idle: got %h expected %h", state, S_IDLE);
        end
    endtask

    task automatic test_abort();
        cpu_latch(1'b0, 20'h00200);
        cpu_ad = 8'h11;
        cpu_en = 1'b1;
        wr_n   = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state !== S_WR1 || {mem_cs, io_cs, oe, wr, ready} !== ST_MEM_WR || data !== 8'h11) begin
            tests_failed++;
            $display("FAIL abort_wr1: got %h/%b/%h expected %h/%b/11", state, {mem_cs, io_cs, oe, wr, ready}, data, S_WR1, ST_MEM_WR);
        end
        @(negedge clk);
        tests_run++;
        if (state !== S_WR2) begin
            tests_failed++;
            $display("FAIL abort_wr2: got %h expected %h", state, S_WR2);
        end
        // A new ALE arrives while the DUT is in WR2.
        ale    = 1'b1;
        a_hi   = 12'h004;
        cpu_ad = 8'h56;
        @(negedge clk);
        tests_run++;
        if ({mem_cs, io_cs, oe, wr, ready} !== ST_QUIET || state !== S_ADDR) begin
            tests_failed++;
            $display("FAIL abort_strobes: got %b/%h expected %b/%h", {mem_cs, io_cs, oe, wr, ready}, state, ST_QUIET, S_ADDR);
        end
        tests_run++;
        if (address !== 20'h00456) begin
            tests_failed++;
            $display("FAIL abort_addr: got %h expected 00456", address);
        end
        ale    = 1'b0;
        cpu_en = 1'b0;
        wr_n   = 1'b1;
        rd_n   = 1'b0;
        @(negedge clk);
        tests_run++;
        if (state !== S_RD1 || {mem_cs, io_cs, oe, wr, ready} !== ST_MEM_RD) begin
            tests_failed++;
            $display("FAIL abort_new_read: got %h/%b expected %h/%b", state, {mem_cs, io_cs, oe, wr, ready}, S_RD1, ST_MEM_RD);
        end
        reset = 1'b1;
        rd_n  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset  = 1'b1;
        ale    = 1'b0;
        iom    = 1'b0;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        a_hi   = 12'h000;
        cpu_en = 1'b0;
        cpu_ad = 8'h00;
        per_rd = 8'h5A;
        @(negedge clk);
        test_reset();
        test_mem_read();
        test_io_write();
        test_miss();
        test_extra_wait();
        test_error();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
